// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision add/sub datapath.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned BIAS  = 127;
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             is_nan;
    logic             is_inf;
  } fp_unpacked_t;

  // Denormals take effective exponent 1 and a zero hidden bit.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t     u;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e        = x[30:23];
    f        = x[22:0];
    u.sign   = x[31];
    u.exp    = (e == '0) ? EXP_W'(1) : e;
    u.sig    = {(e != '0), f};
    u.is_nan = (e == '1) && (f != '0);
    u.is_inf = (e == '1) && (f == '0);
    return u;
  endfunction

endpackage

// File: rtl/fpu_sticky_shr27.sv
// 27-bit logical right shift; every bit shifted out is ORed into bit 0.
module fpu_sticky_shr27 (
  input  logic [26:0] din,
  input  logic [7:0]  shamt,
  output logic [26:0] dout
);

  logic [26:0] mask;

  always_comb begin
    mask = '0;
    dout = '0;
    if (shamt >= 8'd27) begin
      dout = {26'd0, |din};
    end else begin
      mask = (27'd1 << shamt) - 27'd1;
      dout = (din >> shamt) | {26'd0, |(din & mask)};
    end
  end

endmodule

// File: rtl/fpu_addsub_align.sv
// Two-stage operand alignment for the binary32 add/sub path: unpack/compare/swap, then
// shift with sticky capture and conditional two's-complement of the smaller significand.
module fpu_addsub_align
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] add_a,
  output logic [SIG_W-1:0] add_b,
  output logic             add_cin,
  output logic             eff_sub,
  output logic [EXP_W-1:0] exp_r,
  output logic             sign_r,
  output logic [2:0]       grs,
  output logic             special,
  output logic [31:0]      special_val
);

  logic s1_en, s2_en;
  logic s1_valid_q;

  assign s2_en    = ~out_valid | out_ready;
  assign s1_en    = ~s1_valid_q | s2_en;
  assign in_ready = s1_en;

  // Stage 1: unpack, compare, swap, exponent difference, specials.
  fp_unpacked_t     ua, ub;
  logic             sb_eff, a_ge_b;
  logic             eff_sub_d, sign_d, special_d, nan_d;
  logic [SIG_W-1:0] sig_a_d, sig_b_d;
  logic [EXP_W-1:0] exp_big, exp_small, shamt_d;
  logic [31:0]      special_val_d;

  assign ua = fp_unpack(op_a);
  assign ub = fp_unpack(op_b);

  always_comb begin
    sb_eff    = ub.sign ^ sub;
    eff_sub_d = ua.sign ^ sb_eff;
    // Ties keep op_a as the larger operand.
    a_ge_b    = op_a[30:0] >= op_b[30:0];
    sig_a_d   = a_ge_b ? ua.sig : ub.sig;
    sig_b_d   = a_ge_b ? ub.sig : ua.sig;
    exp_big   = a_ge_b ? ua.exp : ub.exp;
    exp_small = a_ge_b ? ub.exp : ua.exp;
    sign_d    = a_ge_b ? ua.sign : sb_eff;
    shamt_d   = exp_big - exp_small;
    nan_d     = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & eff_sub_d);
    special_d = ua.is_nan | ub.is_nan | ua.is_inf | ub.is_inf;
    // A lone infinity is always the larger operand, so sign_d is its sign.
    special_val_d = nan_d ? QNAN : {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic [SIG_W-1:0] s1_sig_a_q, s1_sig_b_q;
  logic [EXP_W-1:0] s1_exp_q, s1_shamt_q;
  logic             s1_eff_sub_q, s1_sign_q, s1_special_q;
  logic [31:0]      s1_special_val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q       <= 1'b0;
      s1_sig_a_q       <= '0;
      s1_sig_b_q       <= '0;
      s1_exp_q         <= '0;
      s1_shamt_q       <= '0;
      s1_eff_sub_q     <= 1'b0;
      s1_sign_q        <= 1'b0;
      s1_special_q     <= 1'b0;
      s1_special_val_q <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sig_a_q       <= sig_a_d;
        s1_sig_b_q       <= sig_b_d;
        s1_exp_q         <= exp_big;
        s1_shamt_q       <= shamt_d;
        s1_eff_sub_q     <= eff_sub_d;
        s1_sign_q        <= sign_d;
        s1_special_q     <= special_d;
        s1_special_val_q <= special_val_d;
      end
    end
  end

  // Stage 2: align, capture guard/round/sticky, negate on effective subtract.
  logic [26:0]      shifted;
  logic [SIG_W-1:0] mb_sh, add_b_d;
  logic [2:0]       grs_raw, grs_d;
  logic             add_cin_d;

  fpu_sticky_shr27 u_shr (
    .din   ({s1_sig_b_q, 3'b000}),
    .shamt (s1_shamt_q),
    .dout  (shifted)
  );

  assign mb_sh   = shifted[26:3];
  assign grs_raw = shifted[2:0];

  // ~x + 1 over 27 bits: the +1 only ripples into the significand when grs_raw is zero.
  always_comb begin
    add_b_d   = mb_sh;
    add_cin_d = 1'b0;
    grs_d     = grs_raw;
    if (s1_eff_sub_q) begin
      add_b_d   = ~mb_sh;
      add_cin_d = (grs_raw == 3'b000);
      grs_d     = ~grs_raw + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      add_a       <= '0;
      add_b       <= '0;
      add_cin     <= 1'b0;
      eff_sub     <= 1'b0;
      exp_r       <= '0;
      sign_r      <= 1'b0;
      grs         <= '0;
      special     <= 1'b0;
      special_val <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        add_a       <= s1_sig_a_q;
        add_b       <= add_b_d;
        add_cin     <= add_cin_d;
        eff_sub     <= s1_eff_sub_q;
        exp_r       <= s1_exp_q;
        sign_r      <= s1_sign_q;
        grs         <= grs_d;
        special     <= s1_special_q;
        special_val <= s1_special_val_q;
      end
    end
  end

endmodule

// File: tb/tb_fpu_addsub_align.sv
// Randomized scoreboard bench for fpu_addsub_align with directed literal and stall/reset cases.
module tb_fpu_addsub_align;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic        add_cin, eff_sub, sign_r, special;
  logic [31:0] op_a, op_b, special_val;
  logic [23:0] add_a, add_b;
  logic [7:0]  exp_r;
  logic [2:0]  grs;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  typedef struct packed {
    logic [23:0] a;
    logic [23:0] b;
    logic        cin;
    logic        es;
    logic [7:0]  e;
    logic        s;
    logic [2:0]  grs;
    logic        sp;
    logic [31:0] spv;
  } exp_t;

  exp_t q[$];

  fpu_addsub_align dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .eff_sub     (eff_sub),
    .exp_r       (exp_r),
    .sign_r      (sign_r),
    .grs         (grs),
    .special     (special),
    .special_val (special_val)
  );

  always #5 clk = ~clk;

  logic [62:0] dut_vec;
  assign dut_vec = {add_a, add_b, add_cin, eff_sub, exp_r, sign_r, grs, special};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: real-valued alignment of the smaller operand as a 27-bit fixed-point number.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t            r;
    logic [31:0]     big, sml;
    logic            sy, sr, es, xn, yn, xi, yi, lost;
    int unsigned     eb, es_, mb, ms, d;
    longint unsigned v, shv;
    sy = y[31] ^ s;
    es = x[31] ^ sy;
    if (y[30:0] > x[30:0]) begin big = y; sml = x; sr = sy; end
    else begin big = x; sml = y; sr = x[31]; end
    eb  = (big[30:23] == 0) ? 1 : int'(big[30:23]);
    es_ = (sml[30:23] == 0) ? 1 : int'(sml[30:23]);
    mb  = int'(big[22:0]) + ((big[30:23] != 0) ? (1 << 23) : 0);
    ms  = int'(sml[22:0]) + ((sml[30:23] != 0) ? (1 << 23) : 0);
    d   = eb - es_;
    v   = longint'(ms) * 8;
    if (d >= 27) begin
      shv  = 0;
      lost = (v != 0);
    end else begin
      shv  = v >> d;
      lost = (v % (64'd1 << d)) != 0;
    end
    if (lost) shv = shv | 64'd1;
    r.a  = 24'(mb);
    r.e  = 8'(eb);
    r.s  = sr;
    r.es = es;
    if (!es) begin
      r.b   = 24'(shv >> 3);
      r.cin = 1'b0;
      r.grs = 3'(shv % 8);
    end else begin
      r.b   = 24'(64'hFFFFFF - (shv >> 3));
      r.cin = (shv % 8) == 0;
      r.grs = 3'((8 - shv % 8) % 8);
    end
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    r.sp  = xn | yn | xi | yi;
    r.spv = (xn | yn | (xi & yi & es)) ? 32'h7FC00000 : {sr, 8'hFF, 23'h0};
    return r;
  endfunction

  function automatic logic [62:0] pack_exp(input exp_t m);
    return {m.a, m.b, m.cin, m.es, m.e, m.s, m.grs, m.sp};
  endfunction

  // Scoreboard: push on accept, compare on emit, and check outputs hold while stalled.
  logic [62:0] held_vec;
  logic [31:0] held_spv;
  bit          held = 0;
  logic [23:0] last_a, last_b;
  logic [7:0]  last_e;
  logic [2:0]  last_grs;
  logic        last_cin, last_es, last_s, last_sp;
  logic [31:0] last_spv;

  always @(negedge clk) begin
    exp_t m;
    if (rst) begin
      q.delete();
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(dut_vec), 64'(held_vec));
        chk("hold_special_val", 64'(special_val), 64'(held_spv));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          m = q.pop_front();
          pops++;
          last_a = add_a; last_b = add_b; last_cin = add_cin; last_es = eff_sub;
          last_e = exp_r; last_s = sign_r; last_grs = grs; last_sp = special;
          last_spv = special_val;
          if (m.sp) begin
            chk("special_flag", 64'(special), 64'd1);
            chk("special_val", 64'(special_val), 64'(m.spv));
          end else begin
            chk("aligned_result", 64'(dut_vec), 64'(pack_exp(m)));
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(op_a, op_b, sub));
      held     = out_valid && !out_ready;
      held_vec = dut_vec;
      held_spv = special_val;
    end
  end

  // All driving happens at posedge+1.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
    bit ok = 0;
    in_valid = 1'b1; op_a = x; op_b = y; sub = s;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("send_accepted", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_dir(input logic [31:0] x, input logic [31:0] y, input logic s);
    int n0 = pops;
    int lat = -1;
    send(x, y, s);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (pops > n0) begin lat = k; break; end
    end
    chk("dir_latency", 64'(lat), 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    k = int'($urandom % 10);
    f = 23'($urandom);
    case (k)
      0: begin e = 8'hFF; if ($urandom % 2 == 0) f = '0; end
      1: e = 8'h00;
      2: begin e = 8'h00; f = '0; end
      3: e = 8'($urandom);
      default: e = 8'(120 + $urandom % 16);
    endcase
    return {1'($urandom), e, f};
  endfunction

  logic [31:0] bva[3];
  logic [31:0] bvb[3];

  initial begin
    exp_t m;
    int   idx;
    bit   acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_data", 64'(dut_vec), 64'd0);
    chk("reset_special_val", 64'(special_val), 64'd0);
    @(posedge clk); #1;

    // Pin the reference model against hand-computed values.
    m = model(32'h3F800000, 32'h3F000000, 1'b1);
    chk("model_sub_b", 64'(m.b), 64'hBFFFFF);
    chk("model_sub_cin", 64'(m.cin), 64'd1);
    m = model(32'h3F800000, 32'h33800001, 1'b0);
    chk("model_d24_grs", 64'(m.grs), 64'd5);
    m = model(32'h3F800000, 32'h33800001, 1'b1);
    chk("model_d24sub_b", 64'(m.b), 64'hFFFFFF);
    chk("model_d24sub_grs", 64'(m.grs), 64'd3);
    m = model(32'h7F800000, 32'h7F800000, 1'b1);
    chk("model_infinf", 64'(m.spv), 64'h7FC00000);

    run_dir(32'h3F800000, 32'h3F800000, 1'b0);
    chk("t1_a", 64'(last_a), 64'h800000);
    chk("t1_b", 64'(last_b), 64'h800000);
    chk("t1_cin_es", 64'({last_cin, last_es}), 64'd0);
    chk("t1_exp", 64'(last_e), 64'd127);
    chk("t1_grs", 64'(last_grs), 64'd0);

    run_dir(32'h3F800000, 32'h3F000000, 1'b1);
    chk("t2_a", 64'(last_a), 64'h800000);
    chk("t2_b", 64'(last_b), 64'hBFFFFF);
    chk("t2_cin_es_s", 64'({last_cin, last_es, last_s}), 64'b110);
    chk("t2_grs", 64'(last_grs), 64'd0);

    run_dir(32'h3F000000, 32'h40000000, 1'b0);
    chk("t3_a", 64'(last_a), 64'h800000);
    chk("t3_b", 64'(last_b), 64'h200000);
    chk("t3_exp", 64'(last_e), 64'd128);
    chk("t3_sign", 64'(last_s), 64'd0);

    run_dir(32'h3F800000, 32'h33800001, 1'b0);
    chk("t4_b", 64'(last_b), 64'h0);
    chk("t4_grs", 64'(last_grs), 64'b101);
    run_dir(32'h3F800000, 32'h33800001, 1'b1);
    chk("t5_b", 64'(last_b), 64'hFFFFFF);
    chk("t5_cin", 64'(last_cin), 64'd0);
    chk("t5_grs", 64'(last_grs), 64'b011);

    run_dir(32'h7F800000, 32'h7F800000, 1'b1);
    chk("t6_special", 64'({last_sp, last_spv}), {31'd0, 1'b1, 32'h7FC00000});
    run_dir(32'h7FC00001, 32'h3F800000, 1'b0);
    chk("t7_nan_a", 64'(last_spv), 64'h7FC00000);
    run_dir(32'h3F800000, 32'hFF800001, 1'b1);
    chk("t8_nan_b", 64'(last_spv), 64'h7FC00000);

    // Backpressure: three offered, two fit.
    bva[0] = 32'h40400000; bvb[0] = 32'h3F800000;
    bva[1] = 32'h41200000; bvb[1] = 32'hC0A00000;
    bva[2] = 32'h3DCCCCCD; bvb[2] = 32'h3E4CCCCD;
    out_ready = 1'b0; idx = 0;
    in_valid = 1'b1; op_a = bva[0]; op_b = bvb[0]; sub = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc && idx < 3) begin
        idx++;
        if (idx < 3) begin op_a = bva[idx]; op_b = bvb[idx]; end
        else in_valid = 1'b0;
      end
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_emit0", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("bp_emit1", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    // Reset during a stall discards both in-flight transactions.
    out_ready = 1'b0;
    send(32'h40000000, 32'h3F800000, 1'b0);
    send(32'h40800000, 32'h40000000, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      op_a      = rnd_fp();
      op_b      = ($urandom % 8 == 0) ? {1'($urandom), op_a[30:0]} : rnd_fp();
      sub       = 1'($urandom);
      out_ready = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
